// File: rtl/mac_input_stage.sv
// mac_input_stage: two-entry skid-buffered input stage with weight-hold reuse for the SD4 MAC array.
module mac_input_stage #(
    parameter int IMG_W = 72,
    parameter int WGT_W = 36,
    parameter int EXP_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_wload,
    input  logic [IMG_W-1:0] image_in,
    input  logic [WGT_W-1:0] weight_in,
    input  logic [EXP_W-1:0] exp_bias_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IMG_W-1:0] image_out,
    output logic [WGT_W-1:0] weight_out,
    output logic [EXP_W-1:0] exp_bias_out
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_nxt;
    logic [IMG_W-1:0] img_s;
    logic [WGT_W-1:0] wgt_s, whold, bw;
    logic [EXP_W-1:0] exp_s, ehold, be;
    logic in_fire, out_fire, ld_out, ld_skid, mv_skid;
    assign in_ready  = state != TWO;
    assign out_valid = state != EMPTY;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign bw        = in_wload ? weight_in : whold;
    assign be        = in_wload ? exp_bias_in : ehold;
    always_comb begin
        state_nxt = state;
        ld_out    = 1'b0;
        ld_skid   = 1'b0;
        mv_skid   = 1'b0;
        if (flush) state_nxt = EMPTY;
        else case (state)
            EMPTY: begin
                ld_out    = in_fire;
                state_nxt = in_fire ? ONE : EMPTY;
            end
            ONE: begin
                ld_out    = in_fire & out_fire;
                ld_skid   = in_fire & ~out_fire;
                state_nxt = ld_skid ? TWO : (out_fire & ~in_fire) ? EMPTY : ONE;
            end
            TWO: begin
                mv_skid   = out_fire;
                state_nxt = out_fire ? ONE : TWO;
            end
            default: state_nxt = EMPTY;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= EMPTY;
        else state <= state_nxt;
    // flushed beats never reach the buffer, so their weight load is dropped too
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            image_out    <= '0;
            weight_out   <= '0;
            exp_bias_out <= '0;
            img_s        <= '0;
            wgt_s        <= '0;
            exp_s        <= '0;
            whold        <= '0;
            ehold        <= '0;
        end else begin
            if (in_fire && in_wload && !flush) begin
                whold <= weight_in;
                ehold <= exp_bias_in;
            end
            if (ld_out) begin
                image_out    <= image_in;
                weight_out   <= bw;
                exp_bias_out <= be;
            end else if (mv_skid) begin
                image_out    <= img_s;
                weight_out   <= wgt_s;
                exp_bias_out <= exp_s;
            end
            if (ld_skid) begin
                img_s <= image_in;
                wgt_s <= bw;
                exp_s <= be;
            end
        end
    end
endmodule

// File: tb/tb_mac_input_stage.sv
// tb_mac_input_stage: table vectors, directed corner sequences and a FIFO scoreboard for mac_input_stage.
module tb_mac_input_stage;
    localparam int IW = 72, WW = 36, EW = 5;
    logic clk = 0, rst = 0, flush = 0, in_valid = 0, in_wload = 0, out_ready = 0;
    logic in_ready, out_valid, r0;
    logic [IW-1:0] image_in = '0, image_out;
    logic [WW-1:0] weight_in = '0, weight_out;
    logic [EW-1:0] exp_bias_in = '0, exp_bias_out;
    int checks = 0, errors = 0;

    mac_input_stage #(.IMG_W(IW), .WGT_W(WW), .EXP_W(EW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_wload(in_wload), .image_in(image_in), .weight_in(weight_in), .exp_bias_in(exp_bias_in),
        .out_valid(out_valid), .out_ready(out_ready), .image_out(image_out),
        .weight_out(weight_out), .exp_bias_out(exp_bias_out));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [IW-1:0] img;
        logic [WW-1:0] wgt;
        logic [EW-1:0] ex;
    } beat_t;
    beat_t sb[$];
    beat_t mon_e, mon_b;
    logic [WW-1:0] m_w = '0;
    logic [EW-1:0] m_e = '0;

    typedef struct {
        logic [IW-1:0] img;
        logic          wl;
        logic [WW-1:0] w;
        logic [EW-1:0] e;
        logic [IW-1:0] x_img;
        logic [WW-1:0] x_w;
        logic [EW-1:0] x_e;
    } vec_t;
    vec_t tv[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [IW-1:0] img, input logic wl, input logic [WW-1:0] w, input logic [EW-1:0] e);
        in_valid = 1; image_in = img; in_wload = wl; weight_in = w; exp_bias_in = e;
    endtask

    task automatic chk_out(input string name, input logic [IW-1:0] img, input logic [WW-1:0] w, input logic [EW-1:0] e);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_image"}, image_out, img);
        chk({name, "_weight"}, weight_out, w);
        chk({name, "_exp"}, exp_bias_out, e);
    endtask

    // scoreboard: queue depth mirrors expected occupancy, beats popped on out_fire
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_w = '0;
            m_e = '0;
        end else begin
            chk("occ_out_valid", out_valid, sb.size() > 0);
            chk("occ_in_ready", in_ready, sb.size() < 2);
            if (flush) sb.delete();
            else begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) chk("unexpected_beat", 1'b1, 1'b0);
                    else begin
                        mon_e = sb.pop_front();
                        chk("sb_image", image_out, mon_e.img);
                        chk("sb_weight", weight_out, mon_e.wgt);
                        chk("sb_exp", exp_bias_out, mon_e.ex);
                    end
                end
                if (in_valid && in_ready) begin
                    mon_b.img = image_in;
                    mon_b.wgt = in_wload ? weight_in : m_w;
                    mon_b.ex  = in_wload ? exp_bias_in : m_e;
                    if (in_wload) begin
                        m_w = weight_in;
                        m_e = exp_bias_in;
                    end
                    sb.push_back(mon_b);
                end
            end
        end
    end

    initial begin
        tv[0] = '{72'hA1, 1'b1, 36'h123456789, 5'h0A, 72'hA1, 36'h123456789, 5'h0A};
        tv[1] = '{72'hA2, 1'b0, 36'hFFFFFFFFF, 5'h1F, 72'hA2, 36'h123456789, 5'h0A};
        tv[2] = '{72'hA3, 1'b0, 36'h0,         5'h00, 72'hA3, 36'h123456789, 5'h0A};
        tv[3] = '{72'hA4, 1'b0, 36'h555555555, 5'h15, 72'hA4, 36'h123456789, 5'h0A};

        repeat (2) cyc();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_image", image_out, '0);
        chk("rst_weight", weight_out, '0);
        chk("rst_exp", exp_bias_out, '0);
        rst = 1;
        cyc();

        // streaming with weight reuse
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            beat(tv[i].img, tv[i].wl, tv[i].w, tv[i].e);
            cyc();
            chk_out("stream", tv[i].x_img, tv[i].x_w, tv[i].x_e);
        end
        in_valid = 0;
        cyc();
        chk("stream_idle", out_valid, 1'b0);

        // backpressure
        out_ready = 0;
        beat(72'hB1, 0, 36'h0, 5'h0);
        cyc();
        beat(72'hB2, 0, 36'h0, 5'h0);
        cyc();
        beat(72'hB3, 0, 36'h0, 5'h0);
        chk("bp_in_ready_full", in_ready, 1'b0);
        cyc();
        chk("bp_hold_ready", in_ready, 1'b0);
        chk_out("bp_b1", 72'hB1, 36'h123456789, 5'h0A);
        out_ready = 1;
        cyc();
        chk_out("bp_b2", 72'hB2, 36'h123456789, 5'h0A);
        chk("bp_ready_back", in_ready, 1'b1);
        cyc();
        chk_out("bp_b3", 72'hB3, 36'h123456789, 5'h0A);
        in_valid = 0;
        cyc();
        chk("bp_idle", out_valid, 1'b0);

        // weight change under stall
        out_ready = 0;
        beat(72'hC1, 1, 36'h1, 5'h01);
        cyc();
        beat(72'hC2, 1, 36'h2, 5'h02);
        cyc();
        chk_out("wc_c1", 72'hC1, 36'h1, 5'h01);
        beat(72'hC3, 0, 36'hF, 5'h0F);
        out_ready = 1;
        cyc();
        chk_out("wc_c2", 72'hC2, 36'h2, 5'h02);
        cyc();
        chk_out("wc_c3", 72'hC3, 36'h2, 5'h02);
        in_valid = 0;
        cyc();

        // flush with two buffered beats and a beat offered
        out_ready = 0;
        beat(72'hD1, 1, 36'h77, 5'h07);
        cyc();
        beat(72'hD2, 0, 36'h0, 5'h0);
        cyc();
        beat(72'hD3, 0, 36'h0, 5'h0);
        flush = 1;
        cyc();
        flush = 0;
        in_valid = 0;
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        out_ready = 1;
        beat(72'hE1, 0, 36'h3, 5'h03);
        cyc();
        chk_out("flush_reuse", 72'hE1, 36'h77, 5'h07);
        in_valid = 0;
        cyc();

        // asynchronous reset mid-stream
        out_ready = 0;
        beat(72'hF1, 1, 36'hAB, 5'h0B);
        cyc();
        beat(72'hF2, 0, 36'h0, 5'h0);
        cyc();
        in_valid = 0;
        #1 rst = 0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_in_ready", in_ready, 1'b1);
        chk("arst_image", image_out, '0);
        chk("arst_weight", weight_out, '0);
        chk("arst_exp", exp_bias_out, '0);
        cyc();
        rst = 1;
        cyc();
        out_ready = 1;
        beat(72'h61, 0, 36'hAB, 5'h0B);
        cyc();
        chk_out("post_rst", 72'h61, 36'h0, 5'h0);
        in_valid = 0;
        cyc();

        // random traffic, probing in_ready against an intra-cycle out_ready toggle
        for (int i = 0; i < 1000; i++) begin
            in_valid    = ($urandom % 4) != 0;
            in_wload    = ($urandom % 8) == 0;
            image_in    = {8'($urandom), $urandom, $urandom};
            weight_in   = {4'($urandom), $urandom};
            exp_bias_in = 5'($urandom);
            r0 = in_ready;
            out_ready = ~out_ready;
            #1;
            chk("no_comb_path", in_ready, r0);
            out_ready = 1'($urandom);
            cyc();
        end
        in_valid = 0;
        out_ready = 1;
        repeat (4) cyc();
        chk("drain_empty", sb.size(), 0);
        chk("drain_out_valid", out_valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
